// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, FSM encodings and bus widths for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int ByteSelBus = 4;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data formatter: picks the addressed big-endian byte/halfword from the
// latched bus word and sign- or zero-extends it according to the load opcode.
module mem_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [7:0]  i_aluop,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte at offset 0 lives in the most significant lane.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[15:0] : i_word[31:16];
  end

  always_comb begin
    o_data = i_word;
    case (i_aluop)
      EXE_LB_OP:  o_data = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: o_data = {24'h000000, w_byte};
      EXE_LH_OP:  o_data = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: o_data = {16'h0000, w_half};
      default:    o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: data-bus handshake, lane select, misalign detect.
// Optional ack watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | pass-through; launches aligned memory ops onto the bus
// BUS   | request held stable until dbus_ack (or watchdog expiry)
// DONE  | one cycle delivering the load result / retiring the store
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [7:0]            mem_aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_reg2_i,
  output logic [4:0]            mem_wd,
  output logic                  mem_wreg,
  output logic [31:0]           mem_wdata,
  output logic                  stallreq,
  output logic                  excp_misalign,
  output logic                  bus_err,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [31:0]           dbus_addr,
  output logic [ByteSelBus-1:0] dbus_sel,
  output logic [31:0]           dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [31:0]           dbus_rdata
);

  lsu_state_e r_state;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic                  w_load;
  logic                  w_store;
  logic                  w_mem;
  logic                  w_misalign;
  logic                  w_go;
  logic [ByteSelBus-1:0] w_sel;
  logic [31:0]           w_wdata;
  logic [31:0]           w_load_data;

  always_comb begin
    w_misalign = 1'b0;
    w_sel      = 4'b1111;
    w_wdata    = mem_reg2_i;
    case (mem_aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        w_sel   = 4'b1000 >> mem_addr_i[1:0];
        w_wdata = {4{mem_reg2_i[7:0]}};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        w_misalign = mem_addr_i[0];
        w_sel      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        w_wdata    = {2{mem_reg2_i[15:0]}};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        w_misalign = |mem_addr_i[1:0];
      end
      default: ;
    endcase
  end

  assign w_load  = is_load_op(mem_aluop_i);
  assign w_store = is_store_op(mem_aluop_i);
  assign w_mem   = w_load | w_store;
  assign w_go    = w_mem & ~w_misalign;

  mem_load_align u_align (
    .i_word    (r_rdata),
    .i_addr_lo (mem_addr_i[1:0]),
    .i_aluop   (mem_aluop_i),
    .o_data    (w_load_data)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [CNT_W-1:0] w_tmo_nxt;
  logic             w_tmo_hit;

  assign w_tmo_nxt = r_tmo_cnt + 1'b1;
  assign w_tmo_hit = (w_tmo_nxt == TIMEOUT_CYCLES[CNT_W-1:0]);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rdata    <= 32'h0;
      r_bus_err  <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0;
      dbus_sel   <= '0;
      dbus_wdata <= 32'h0;
`ifdef MEM_BUS_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bus_err <= 1'b0;
          if (w_go) begin
            r_state    <= ST_BUS;
            dbus_req   <= 1'b1;
            dbus_we    <= w_store;
            dbus_addr  <= {mem_addr_i[31:2], 2'b00};
            dbus_sel   <= w_sel;
            dbus_wdata <= w_wdata;
`ifdef MEM_BUS_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
          end
        end
        ST_BUS: begin
          if (dbus_ack) begin
            r_rdata  <= dbus_rdata;
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            r_state  <= ST_DONE;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (w_tmo_hit) begin
            dbus_req  <= 1'b0;
            dbus_we   <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_tmo_cnt <= w_tmo_nxt;
          end
`endif
        end
        ST_DONE: begin
          r_bus_err <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_err = r_bus_err;

  // Memory ops never write back before DONE; aborted loads never write back.
  always_comb begin
    mem_wd        = mem_wd_i;
    mem_wreg      = mem_wreg_i;
    mem_wdata     = mem_wdata_i;
    stallreq      = 1'b0;
    excp_misalign = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem) begin
          mem_wreg      = 1'b0;
          stallreq      = ~w_misalign;
          excp_misalign = w_misalign;
        end
      end
      ST_BUS: begin
        mem_wreg = 1'b0;
        stallreq = 1'b1;
      end
      ST_DONE: begin
        if (w_load && !r_bus_err) begin
          mem_wdata = w_load_data;
        end else begin
          mem_wreg = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected write-back pushed at issue, popped at retire.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_reg2_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        excp_misalign;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .excp_misalign(excp_misalign), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_t;

  wb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return (a == 2'd0) ? 4'b1000 : (a == 2'd1) ? 4'b0100 :
                                               (a == 2'd2) ? 4'b0010 : 4'b0001;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] r);
    case (op)
      EXE_SB_OP: return {r[7:0], r[7:0], r[7:0], r[7:0]};
      EXE_SH_OP: return {r[15:0], r[15:0]};
      default:   return r;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    sh = 8 * (3 - int'(a));
    b  = 8'(w >> sh);
    h  = 16'(w >> (a[1] ? 0 : 16));
    case (op)
      EXE_LB_OP:  return 32'($signed(b));
      EXE_LBU_OP: return {24'h0, b};
      EXE_LH_OP:  return 32'($signed(h));
      EXE_LHU_OP: return {16'h0, h};
      default:    return w;
    endcase
  endfunction

  task automatic set_idle();
    mem_aluop_i = 8'h25;
    mem_addr_i  = 32'h0;
    mem_reg2_i  = 32'h0;
    mem_wd_i    = 5'd0;
    mem_wreg_i  = 1'b0;
    mem_wdata_i = 32'h0;
  endtask

  task automatic pop_wb(input string tag);
    wb_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_wd"}, 32'(mem_wd), 32'(e.wd));
      check({tag, "_wreg"}, 32'(mem_wreg), 32'(e.wreg));
      check({tag, "_wdata"}, mem_wdata, e.wdata);
    end
  endtask

  task automatic drive_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
    mem_aluop_i = op;
    mem_addr_i  = addr;
    mem_reg2_i  = reg2;
    mem_wd_i    = 5'(addr[6:2] ^ 5'd7);
    mem_wreg_i  = 1'b1;
    mem_wdata_i = 32'hCAFE0000 ^ addr;
  endtask

  task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] rdata, input int ack_dly);
    wb_t  e;
    logic ld;
    int   stalls;
    ld = is_load_op(op);
    stalls = 0;
    @(posedge clk); #1;
    drive_op(op, addr, reg2);
    e.wd    = mem_wd_i;
    e.wreg  = ld;
    e.wdata = ld ? model_load(op, addr[1:0], rdata) : mem_wdata_i;
    sb_q.push_back(e);
    @(negedge clk);
    check({tag, "_issue_stall"}, 32'(stallreq), 32'd1);
    check({tag, "_issue_req"}, 32'(dbus_req), 32'd0);
    stalls += int'(stallreq);
    for (int n = 0; n <= ack_dly; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_req"}, 32'(dbus_req), 32'd1);
      check({tag, "_we"}, 32'(dbus_we), 32'(!ld));
      check({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
      check({tag, "_sel"}, 32'(dbus_sel), 32'(model_sel(op, addr[1:0])));
      check({tag, "_bwdata"}, dbus_wdata, ld ? dbus_wdata : model_wdata(op, reg2));
      stalls += int'(stallreq);
      if (n == ack_dly) begin
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
      end
    end
    @(posedge clk); #1;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check({tag, "_done_stall"}, 32'(stallreq), 32'd0);
    check({tag, "_done_req"}, 32'(dbus_req), 32'd0);
    check({tag, "_done_err"}, 32'(bus_err), 32'd0);
    pop_wb(tag);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(ack_dly + 2));
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic misalign_op(input string tag, input logic [7:0] op, input logic [31:0] addr);
    wb_t e;
    @(posedge clk); #1;
    drive_op(op, addr, 32'h12345678);
    e.wd = mem_wd_i; e.wreg = 1'b0; e.wdata = mem_wdata_i;
    sb_q.push_back(e);
    @(negedge clk);
    check({tag, "_excp"}, 32'(excp_misalign), 32'd1);
    check({tag, "_stall"}, 32'(stallreq), 32'd0);
    pop_wb(tag);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_req_after"}, 32'(dbus_req), 32'd0);
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    wb_t         e;
    logic [7:0]  ops[8];
    logic [7:0]  op;
    logic [31:0] a;
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    rst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_we", 32'(dbus_we), 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_sel", 32'(dbus_sel), 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory pass-through
    mem_aluop_i = 8'h25; mem_wd_i = 5'd5; mem_wreg_i = 1'b1; mem_wdata_i = 32'h1234;
    e.wd = 5'd5; e.wreg = 1'b1; e.wdata = 32'h1234;
    sb_q.push_back(e);
    @(negedge clk);
    check("nop_stall", 32'(stallreq), 32'd0);
    check("nop_excp", 32'(excp_misalign), 32'd0);
    pop_wb("nop");
    @(posedge clk); #1;
    @(negedge clk);
    check("nop_req", 32'(dbus_req), 32'd0);

    mem_op("lb", EXE_LB_OP, 32'h101, 32'h0, 32'h11F23344, 0);
    mem_op("sh", EXE_SH_OP, 32'h202, 32'h0000ABCD, 32'h0, 3);
    mem_op("lbu", EXE_LBU_OP, 32'h103, 32'h0, 32'h11F233C4, 1);
    mem_op("lh", EXE_LH_OP, 32'h102, 32'h0, 32'h12348001, 0);
    mem_op("lhu", EXE_LHU_OP, 32'h100, 32'h0, 32'h92340001, 2);
    mem_op("lw", EXE_LW_OP, 32'h3FC, 32'h0, 32'hA5A55A5A, 0);
    mem_op("sb", EXE_SB_OP, 32'h001, 32'h0000005A, 32'h0, 0);
    mem_op("sw", EXE_SW_OP, 32'h040, 32'h87654321, 32'h0, 1);

    misalign_op("mis_lw", EXE_LW_OP, 32'h3);
    misalign_op("mis_lh", EXE_LH_OP, 32'h101);
    misalign_op("mis_sh", EXE_SH_OP, 32'h203);
    misalign_op("mis_sw", EXE_SW_OP, 32'h2);

    for (int k = 0; k < 12; k++) begin
      op = ops[$urandom_range(7)];
      a  = $urandom;
      if (op == EXE_LW_OP || op == EXE_SW_OP) a[1:0] = 2'b00;
      else if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) a[0] = 1'b0;
      mem_op("rnd", op, a, $urandom, $urandom, int'($urandom_range(3)));
    end

`ifdef MEM_BUS_TIMEOUT_EN
    @(posedge clk); #1;
    drive_op(EXE_LW_OP, 32'h600, 32'h0);
    e.wd = mem_wd_i; e.wreg = 1'b0; e.wdata = mem_wdata_i;
    sb_q.push_back(e);
    for (int n = 0; n < TMO; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("tmo_req", 32'(dbus_req), 32'd1);
      check("tmo_err_early", 32'(bus_err), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_err", 32'(bus_err), 32'd1);
    check("tmo_req_drop", 32'(dbus_req), 32'd0);
    check("tmo_stall", 32'(stallreq), 32'd0);
    pop_wb("tmo");
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check("tmo_err_pulse", 32'(bus_err), 32'd0);
`endif

    // Reset during an outstanding access with no ack
    @(posedge clk); #1;
    drive_op(EXE_LW_OP, 32'h500, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_req", 32'(dbus_req), 32'd1);
      check("hold_stall", 32'(stallreq), 32'd1);
      check("hold_err", 32'(bus_err), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("brst_req", 32'(dbus_req), 32'd0);
    check("brst_we", 32'(dbus_we), 32'd0);
    check("brst_addr", dbus_addr, 32'd0);
    check("brst_sel", 32'(dbus_sel), 32'd0);
    check("brst_wdata", dbus_wdata, 32'd0);
    check("brst_stall", 32'(stallreq), 32'd0);

    mem_op("post_rst", EXE_LW_OP, 32'h504, 32'h0, 32'h0BADF00D, 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit. Sits between the ex_mem pipeline register and the mem_wb pipeline register.
- Non-memory instructions pass through combinationally.
- Loads and stores run a multi-cycle handshake on the data bus. The unit holds the pipeline via stallreq until the access completes.
- It also formats load data (byte/halfword select, sign/zero extension) and detects misaligned accesses.

Parameters:
- TIMEOUT_CYCLES, 255: ack watchdog limit in cycles. Used only when MEM_BUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- mem_wd_i  in  5  destination register from ex_mem
- mem_wreg_i  in  1  write enable from ex_mem
- mem_wdata_i  in  32  ALU result from ex_mem
- mem_aluop_i  in  8  operation code (`AluOpBus)
- mem_addr_i  in  32  effective address
- mem_reg2_i  in  32  store data
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- stallreq  out  1  pipeline hold request to ctrl
- excp_misalign  out  1  misaligned-access flag, combinational
- bus_err  out  1  timeout abort flag, one cycle
- dbus_req  out  1  bus request (registered)
- dbus_we  out  1  write strobe (registered)
- dbus_addr  out  32  word address, low 2 bits zero (registered)
- dbus_sel  out  4  byte lanes (registered)
- dbus_wdata  out  32  store data replicated into lanes (registered)
- dbus_ack  in  1  transfer complete
- dbus_rdata  in  32  load data, valid with ack

Behaviour:
- Reset: state IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0; internal rdata latch=0; bus_err=0.
- Reset applied in any state returns to IDLE at the next edge and drops dbus_req. The in-flight access is discarded.
- FSM states: IDLE, BUS, DONE.
- IDLE, non-memory op: mem_wd/mem_wreg/mem_wdata = inputs, same cycle; stallreq=0.
- IDLE, aligned memory op: stallreq=1. Next edge → BUS, with dbus_req=1, dbus_we=(store), dbus_addr={addr[31:2],2'b00} and dbus_sel/dbus_wdata loaded.
- BUS: stallreq=1, dbus_req held with all bus signals stable until dbus_ack. On the ack edge, latch dbus_rdata, drop dbus_req/dbus_we, → DONE.
- DONE: stallreq=0. For loads, mem_wdata = formatted latched data and mem_wreg = mem_wreg_i. For stores, mem_wreg=0. Next edge → IDLE.
- Upstream holds all inputs stable while stallreq=1.
- Minimum memory-op latency: 3 cycles with ack in the first BUS cycle.
- Lanes are big-endian:
  - Byte access: addr[1:0]=0→sel 1000, 1→0100, 2→0010, 3→0001.
  - Half access: addr[1]=0→1100, 1→0011.
  - Word access: 1111.
  - Store data: byte replicated ×4, halfword ×2.
- Load formatting: LB/LH sign-extend; LBU/LHU zero-extend; LW is a full word.
- Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0): no bus access, state stays IDLE, stallreq=0, mem_wreg=0, excp_misalign=1 for that cycle.
- excp_misalign=0 for all other ops.
- Upstream destination register $0 needs no special handling here; the register file ignores writes to $0.

Optional Feature:
MEM_BUS_TIMEOUT_EN
- Defined: an 8-bit-or-wider counter clears on entering BUS and increments each BUS cycle without ack.
- When the count reaches TIMEOUT_CYCLES: drop dbus_req, → DONE with mem_wreg forced 0, and bus_err=1 for the DONE cycle.
- Undefined: no counter, bus_err tied 0, BUS waits indefinitely.

Decomposition:
- precompiled.v additions: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP codes, the FSM state encodings (2 bits), and the ByteSelBus width.
- One sub-module: mem_load_align, purely combinational. Takes latched word, addr[1:0] and aluop; returns the formatted 32-bit load result.

Test Plan:
- Non-memory op: wd=5, wreg=1, wdata=0x1234 → same-cycle outputs identical, stallreq=0, dbus_req stays 0.
- LB at addr 0x101, rdata=0x11F23344, ack on the first BUS cycle → dbus_sel=0100, dbus_addr=0x100; DONE mem_wdata=0xFFFFFFF2; stallreq high for exactly 2 cycles.
- SH at addr 0x202, reg2=0x0000ABCD, ack delayed 3 cycles → dbus_we=1, sel=0011, wdata=0xABCDABCD held stable 4 cycles; DONE mem_wreg=0.
- LW at addr 0x3 → excp_misalign=1, dbus_req never asserts, mem_wreg=0, stallreq=0.
- rst pulsed while in BUS → next edge: dbus_req=0, state IDLE, all bus outputs 0.
- MEM_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack on LW → abort after 4 BUS cycles, bus_err=1 for one cycle, mem_wreg=0.
